// File: rtl/mont_modexp_ctrl.sv
// mont_modexp_ctrl: left-to-right square-and-multiply sequencer that computes
// i_Base^i_Exp mod i_Mod through an external Montgomery multiplier.
module mont_modexp_ctrl #(
  parameter int K_BITS = 256,
  parameter int E_BITS = 256
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Start,
  input  logic [K_BITS-1:0] i_Base,
  input  logic [E_BITS-1:0] i_Exp,
  input  logic [K_BITS-1:0] i_Mod,
  input  logic [K_BITS-1:0] i_R2,
  output logic              o_Busy,
  output logic              o_Done,
  output logic [K_BITS-1:0] o_Result,
  output logic              o_Mul_Start,
  output logic [K_BITS-1:0] o_Mul_A,
  output logic [K_BITS-1:0] o_Mul_B,
  output logic [K_BITS-1:0] o_Mul_M,
  input  logic [K_BITS-1:0] i_Mul_P,
  input  logic              i_Mul_Done
);
  localparam int IW = (E_BITS > 1) ? $clog2(E_BITS) : 1;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CBASE = 3'd2;
  localparam logic [2:0] S_CONE  = 3'd3;
  localparam logic [2:0] S_SQ    = 3'd4;
  localparam logic [2:0] S_MUL   = 3'd5;
  localparam logic [2:0] S_COUT  = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;
  localparam logic [K_BITS-1:0] ONE = K_BITS'(1);

  logic [2:0]        r_state, w_nxt, w_tgt;
  logic              r_rel, r_start, w_last, w_dec;
  logic [K_BITS-1:0] r_base, r_mod, r_r2, r_base_m, r_acc, r_result, r_a, r_b, w_a, w_b;
  logic [E_BITS-1:0] r_exp;
  logic [IW-1:0]     r_idx;

  // In RELEASE the operands are prepared for the following state so the next
  // issue can start on the same edge that sees i_Mul_Done low.
  always_comb begin
    w_last = r_idx == '0;
    w_nxt  = (r_state == S_CBASE) ? S_CONE :
             (r_state == S_CONE) ? S_SQ :
             (r_state == S_SQ && r_exp[r_idx]) ? S_MUL :
             (r_state == S_SQ || r_state == S_MUL) ? (w_last ? S_COUT : S_SQ) : S_DONE;
    w_dec  = (r_state == S_MUL || (r_state == S_SQ && !r_exp[r_idx])) && !w_last;
    w_tgt  = r_rel ? w_nxt : r_state;
    w_a    = (w_tgt == S_CBASE) ? r_base : (w_tgt == S_CONE) ? ONE : r_acc;
    w_b    = (w_tgt == S_CBASE || w_tgt == S_CONE) ? r_r2 :
             (w_tgt == S_SQ) ? r_acc : (w_tgt == S_MUL) ? r_base_m : ONE;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state  <= S_IDLE;
      r_rel    <= 1'b0;
      r_start  <= 1'b0;
      r_base   <= '0;
      r_mod    <= '0;
      r_r2     <= '0;
      r_exp    <= '0;
      r_idx    <= '0;
      r_base_m <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_a      <= '0;
      r_b      <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_Start) begin
          r_base  <= i_Base;
          r_exp   <= i_Exp;
          r_mod   <= i_Mod;
          r_r2    <= i_R2;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_idx   <= IW'(E_BITS - 1);
          r_rel   <= 1'b0;
          r_state <= S_CBASE;
        end
        S_DONE: r_state <= S_IDLE;
        default: if (!r_rel) begin
          if (!r_start) begin
            if (!i_Mul_Done) begin
              r_start <= 1'b1;
              r_a     <= w_a;
              r_b     <= w_b;
            end
          end else if (i_Mul_Done) begin
            r_start <= 1'b0;
            r_rel   <= 1'b1;
            if (r_state == S_CBASE) r_base_m <= i_Mul_P;
            else if (r_state == S_COUT) r_result <= i_Mul_P;
            else r_acc <= i_Mul_P;
          end
        end else if (!i_Mul_Done) begin
          r_rel   <= 1'b0;
          r_state <= w_nxt;
          if (w_dec) r_idx <= r_idx - 1'b1;
          if (w_nxt != S_DONE) begin
            r_start <= 1'b1;
            r_a     <= w_a;
            r_b     <= w_b;
          end
        end
      endcase
    end
  end

  assign o_Busy      = r_state != S_IDLE && r_state != S_DONE;
  assign o_Done      = r_state == S_DONE;
  assign o_Result    = r_result;
  assign o_Mul_Start = r_start;
  assign o_Mul_A     = r_a;
  assign o_Mul_B     = r_b;
  assign o_Mul_M     = r_mod;
endmodule

// File: tb/tb_mont_modexp_ctrl.sv
// tb_mont_modexp_ctrl: drives the sequencer with a behavioural Montgomery
// multiplier and checks results against a plain modexp model.
module tb_mont_modexp_ctrl;
  localparam int K = 256;
  localparam int E = 8;
  typedef logic [K-1:0] k_t;
  typedef logic [767:0] w_t;

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, mdone = 1'b0;
  k_t base = '0, mod = '0, r2 = '0, mp = '0;
  logic [E-1:0] expo = '0;
  logic busy, done, mstart;
  k_t result, ma, mb, mm;
  int checks = 0, errors = 0, hs = 0, n_done = 0, maxw = 0;
  k_t q[$];

  always #5 clk = ~clk;

  mont_modexp_ctrl #(.K_BITS(K), .E_BITS(E)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start), .i_Base(base), .i_Exp(expo),
    .i_Mod(mod), .i_R2(r2), .o_Busy(busy), .o_Done(done), .o_Result(result),
    .o_Mul_Start(mstart), .o_Mul_A(ma), .o_Mul_B(mb), .o_Mul_M(mm),
    .i_Mul_P(mp), .i_Mul_Done(mdone)
  );

  function automatic k_t monpro(k_t a, k_t b, k_t m);
    w_t t;
    t = w_t'(a) * w_t'(b);
    for (int i = 0; i < K; i++) begin
      if (t[0]) t = t + w_t'(m);
      t = t >> 1;
    end
    t = t % w_t'(m);
    return t[K-1:0];
  endfunction

  function automatic k_t modexp(k_t b, logic [E-1:0] e, k_t m);
    w_t r, x;
    r = w_t'(1) % w_t'(m);
    x = w_t'(b) % w_t'(m);
    for (int i = 0; i < E; i++) begin
      if (e[i]) r = (r * x) % w_t'(m);
      x = (x * x) % w_t'(m);
    end
    return r[K-1:0];
  endfunction

  function automatic k_t r2f(k_t m);
    w_t t;
    t = (w_t'(1) << (2 * K)) % w_t'(m);
    return t[K-1:0];
  endfunction

  task automatic chk(string nm, k_t act, k_t want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic fail(string nm);
    checks++;
    errors++;
    $display("FAIL %s got none expected event", nm);
  endtask

  // Multiplier: random Done-rise and Done-fall delays, level handshake.
  initial begin : mul_model
    int ms, cnt;
    k_t a, b, m;
    ms = 0; cnt = 0; a = '0; b = '0; m = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        ms = 0;
        mdone = 1'b0;
      end else if (ms == 0) begin
        if (mstart) begin
          a = ma; b = mb; m = mm;
          cnt = $urandom_range(maxw, 0);
          hs++;
          ms = 1;
        end
      end else if (ms == 1) begin
        if (cnt == 0) begin
          mp = monpro(a, b, m);
          mdone = 1'b1;
          ms = 2;
        end else cnt--;
      end else if (ms == 2) begin
        if (!mstart) begin
          cnt = $urandom_range(maxw, 0);
          ms = 3;
        end
      end else begin
        if (cnt == 0) begin
          mdone = 1'b0;
          ms = 0;
        end else cnt--;
      end
    end
  end

  initial begin : cmp
    logic ps, pd, po;
    k_t pa, pb, pm;
    ps = 1'b0; pd = 1'b0; po = 1'b0; pa = '0; pb = '0; pm = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mstart && !ps) chk("start_rise_on_done", K'(pd), '0);
        if (mstart && ps) begin
          chk("op_a_stable", ma, pa);
          chk("op_b_stable", mb, pb);
          chk("op_m_stable", mm, pm);
        end
        if (done) begin
          n_done++;
          chk("done_single_cycle", K'(po), '0);
          if (q.size() == 0) fail("done_unexpected");
          else chk("result", result, q.pop_front());
        end
      end
      ps = mstart; pd = mdone; po = done; pa = ma; pb = mb; pm = mm;
    end
  end

  task automatic wait_done();
    int i;
    i = 0;
    while (!done && i < 5000) begin
      @(negedge clk);
      i++;
    end
    if (!done) begin
      fail("done_timeout");
      q.delete();
    end
  endtask

  task automatic wait_hs(int n);
    int i;
    i = 0;
    while (hs < n && i < 5000) begin
      @(negedge clk);
      i++;
    end
    if (hs < n) fail("handshake_timeout");
  endtask

  task automatic go(k_t b, logic [E-1:0] e, k_t m, k_t want);
    base = b; expo = e; mod = m; r2 = r2f(m);
    q.push_back(want);
    hs = 0; n_done = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic finish_run(string nm, int want_hs);
    wait_done();
    repeat (2) @(negedge clk);
    chk({nm, "_handshakes"}, K'(hs), K'(want_hs));
    chk({nm, "_done_count"}, K'(n_done), K'(1));
  endtask

  initial begin
    k_t m, b;
    logic [E-1:0] e;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", K'(busy), '0);
    chk("rst_done", K'(done), '0);
    chk("rst_result", result, '0);
    chk("rst_mul_start", K'(mstart), '0);
    chk("rst_mul_a", ma, '0);
    chk("rst_mul_b", mb, '0);
    chk("rst_mul_m", mm, '0);
    rst_n = 1'b1;
    chk("model_pin_modexp", modexp(7, 5, 13), 11);
    for (int p = 0; p < 2; p++) begin
      maxw = (p == 0) ? 0 : 20;
      go(7, 8'd5, 13, 11);   finish_run("b7_e5", 13);
      go(7, 8'd0, 13, 1);    finish_run("e0", 11);
      go(7, 8'd1, 13, 7);    finish_run("e1", 12);
      go(2, 8'hFF, 13, 8);   finish_run("b2_eFF", 19);
    end
    maxw = 5;
    go(7, 8'd5, 13, 11);
    wait_hs(3);
    @(negedge clk);
    base = 2; expo = 8'hFF; start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done();
    repeat (5) @(negedge clk);
    chk("ignored_start_not_queued", K'(busy), '0);
    chk("ignored_start_done_count", K'(n_done), K'(1));
    maxw = 0;
    base = 7; expo = 8'd5; mod = 13; r2 = r2f(13);
    q.push_back(11); q.push_back(8);
    n_done = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    base = 2; expo = 8'hFF;
    wait_done();
    @(negedge clk) chk("b2b_idle_gap", K'(busy), '0);
    @(negedge clk) chk("b2b_restart", K'(busy), K'(1));
    start = 1'b0;
    wait_done();
    repeat (2) @(negedge clk);
    chk("b2b_done_count", K'(n_done), K'(2));
    maxw = 3;
    go(7, 8'd5, 13, 11);
    wait_hs(4);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", K'(busy), '0);
    chk("async_rst_mul_start", K'(mstart), '0);
    chk("async_rst_result", result, '0);
    q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    go(7, 8'd5, 13, 11);
    finish_run("post_reset", 13);
    for (int v = 0; v < 50; v++) begin
      maxw = $urandom_range(4, 0);
      for (int w = 0; w < K / 32; w++) m[w*32 +: 32] = $urandom;
      m[K-1] = 1'b0;
      m[0] = 1'b1;
      if (m < 3) m = 3;
      for (int w = 0; w < K / 32; w++) b[w*32 +: 32] = $urandom;
      b = b % m;
      e = E'($urandom);
      go(b, e, m, modexp(b, e, m));
      finish_run("rand", 3 + E + $countones(e));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mont_modexp_ctrl.md
# mont_modexp_ctrl

Modular-exponentiation sequencer sitting directly upstream of the Montgomery multiplier: it computes o_Result = i_Base^i_Exp mod i_Mod. It does this by issuing a sequence of Montgomery products (MonPro(A,B) = A·B·2^-K_BITS mod m) over the multiplier's level Start/Done handshake and consuming each product. Domain conversion in and out is done with the same multiplier, using a caller-supplied R² mod m.

## Interface
- K_BITS, 256: operand/modulus width; must equal the multiplier's K_BITS.
- E_BITS, 256: exponent width.

- i_Clk  in  1  clock.
- i_Rst_n  in  1  asynchronous, active-low reset. Top level drives the multiplier's active-high reset from the same net, inverted.
- i_Start  in  1  request; sampled only in IDLE.
- i_Base  in  K_BITS  base; precondition i_Base < i_Mod.
- i_Exp  in  E_BITS  exponent.
- i_Mod  in  K_BITS  modulus; precondition odd, 1 < m < 2^(K_BITS-1).
- i_R2  in  K_BITS  2^(2·K_BITS) mod m.
- o_Busy  out  1  high from LOAD through CONV_OUT.
- o_Done  out  1  one-cycle pulse, result valid.
- o_Result  out  K_BITS  final value; held until the next accepted start.
- o_Mul_Start  out  1  level request to the multiplier.
- o_Mul_A, o_Mul_B, o_Mul_M  out  K_BITS  multiplier operands; registered, stable while o_Mul_Start is high.
- i_Mul_P  in  K_BITS  multiplier result.
- i_Mul_Done  in  1  multiplier done level.

## Operation
- Reset values: all outputs 0; state IDLE. Internal regs cleared: base_m, acc, latched exp/mod/R2, bit index.
- IDLE: on i_Start=1, latch i_Base, i_Exp, i_Mod and i_R2, then go to LOAD. Input changes after the latch have no effect.
- LOAD: set bit index = E_BITS-1, then go to CONV_BASE.
- CONV_BASE: base_m = MonPro(base, R2).
- CONV_ONE: acc = MonPro(1, R2), giving R mod m.
- SQUARE: acc = MonPro(acc, acc).
  - If exp[idx]=1, go to MULT.
  - Else, if idx=0, go to CONV_OUT; otherwise decrement idx and stay in SQUARE.
- MULT: acc = MonPro(acc, base_m). Then, if idx=0, go to CONV_OUT; else decrement idx and return to SQUARE.
- CONV_OUT: o_Result = MonPro(acc, 1), then go to DONE.
- DONE: pulse o_Done for 1 cycle, then return to IDLE.
- Every state is scanned; leading zero exponent bits are not skipped.
- MonPro count = 3 + E_BITS + popcount(exp).
- Every MonPro state uses two phases:
  - ISSUE: drive A/B/M, assert o_Mul_Start, and hold until i_Mul_Done=1 is sampled. Capture i_Mul_P into the destination register on that edge, drop o_Mul_Start, and go to RELEASE.
  - RELEASE: hold o_Mul_Start=0 until i_Mul_Done=0 is sampled, then advance the state.
- o_Mul_Start never rises while i_Mul_Done=1.
- i_Start while o_Busy=1 is ignored; it is not queued.
- An i_Start held high through DONE starts a new run from IDLE on the next cycle.
- i_Exp=0 gives o_Result=1. Behaviour is undefined if preconditions on i_Base/i_Mod are violated.

## Timing
- Start latch: IDLE→LOAD on the edge where i_Start is sampled; o_Busy rises the next cycle.
- o_Mul_Start for CONV_BASE rises 2 cycles after the i_Start sample.
- Done→Start-low: o_Mul_Start falls 1 cycle after i_Mul_Done is first seen high.
- Next issue: o_Mul_Start rises 1 cycle after i_Mul_Done is seen low.
- The multiplier latency is arbitrary; the controller tolerates any number of wait cycles.
- Against the reference multiplier (K_BITS+4 cycles start→done, 1 cycle done-fall), each MonPro costs K_BITS+7 cycles.
- o_Done asserts 1 cycle after the CONV_OUT capture; o_Result updates on that same capture edge.
- Reset asserted mid-run: outputs and o_Mul_Start go to 0 immediately (asynchronously). The run is abandoned; the next i_Start after release runs cleanly.

## Test plan
- K_BITS=8, E_BITS=8, m=13, R2=3, base=7, exp=5 → o_Result=11; 13 MonPro handshakes; o_Done pulses exactly once.
- Same parameters, exp=0 → 1; exp=1 → 7; base=2, exp=0xFF → 8 with 19 handshakes.
- Bench multiplier model with random 0–20 extra wait cycles on Done rise and Done fall → results identical. Check the protocol every cycle: o_Mul_Start never rises while i_Mul_Done=1, and operands stay stable while o_Mul_Start=1.
- i_Start pulsed mid-run with different operands → ignored; first result still 11. Back-to-back runs with i_Start held high → second run starts the cycle after DONE.
- Assert i_Rst_n=0 during SQUARE → o_Busy, o_Mul_Start and o_Result are 0 immediately. After release, base=7, exp=5 → 11.
- K_BITS=256 with random odd m < 2^255 and random base/exp, checked against a software modexp → exact match over 50 vectors.
